uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage of the SoC UART: turns the asynchronous `UART_RX_i` line into bytes the core can read. It feeds the SoC's memory-mapped UART register block, which pops bytes for firmware and echoes them out through the transmit path. The frame format is 8N1, LSB first, with a fixed integer clocks-per-bit divider. Received bytes are buffered in a small FIFO with sticky frame-error and overrun flags.

## Interface
- `CLKS_PER_BIT`, 32: clock cycles per serial bit; even, ≥4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2. Ignored when the FIFO is compiled out.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `rx_i`  in  1  raw serial line; idles high; asynchronous to `clk`.
- `rd_en_i`  in  1  pop the FIFO head at the clock edge; ignored when `valid_o`=0.
- `clr_i`  in  1  clear the sticky flags.
- `data_o`  out  8  FIFO head (show-ahead); 0 when empty.
- `valid_o`  out  1  FIFO not empty.
- `busy_o`  out  1  frame in progress (state ≠ IDLE).
- `frame_err_o`  out  1  sticky: stop bit sampled low.
- `overrun_o`  out  1  sticky: byte dropped because the FIFO was full.

## Operation
- `rx_i` passes through a 2-flop synchronizer (`rxs`). Both flops reset to 1.
- Falling-edge detect compares `rxs` with its previous value. A line stuck low never retriggers a frame.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. Bit index is 3 bits.
- FSM states:
  - IDLE: on a falling edge → START, counter cleared.
  - START: at count `CLKS_PER_BIT/2-1`, sample `rxs`. If 0 → DATA. If 1 → IDLE (glitch, nothing recorded).
  - DATA: every `CLKS_PER_BIT` cycles, shift `rxs` into bit[index], LSB first. After bit 7 → STOP.
  - STOP: at the sample point, if `rxs`=1, push the byte. If `rxs`=0, set `frame_err_o` and discard the byte. Either way → IDLE.
- FIFO push and pop rules:
  - Push and pop in the same cycle while full: allowed. No overrun; the count is unchanged.
  - Push while full with no pop: byte dropped, `overrun_o` set, contents untouched.
  - Pop while empty: no effect.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
- `clr_i` clears both sticky flags. If a flag-setting event occurs in the same cycle, set wins.
- Reset mid-frame aborts the frame: the partial byte is lost and the FIFO is emptied.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `busy_o`=0, `frame_err_o`=0, `overrun_o`=0. FSM in IDLE, pointers at 0.
- Edge-detect cycle E is the first cycle `rxs`=0 after `rxs`=1. This is 2 cycles after `rx_i` falls, aligned to `clk`.
- START check: E+`CLKS_PER_BIT/2`.
- Data bit i (0..7) sample: E+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
- Stop-bit sample: E+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`. The push happens at this edge.
- `valid_o`/`data_o` update 1 cycle after the push. With default parameters this is E+305.
- `busy_o` rises at E+1 and falls the cycle after the stop sample.
- A pop updates `data_o`/`valid_o` in the cycle after the `rd_en_i` edge.
- Flags assert 1 cycle after the causing sample or push.
- Back-to-back frames are supported: a new start edge is accepted in the first IDLE cycle.

## Configuration
- `UART_RX_FIFO_EN` defined: `FIFO_DEPTH`-entry circular FIFO as described above.
- `UART_RX_FIFO_EN` undefined: single 8-bit holding register with a full bit; `FIFO_DEPTH` is ignored.
  - `valid_o` reflects the full bit.
  - A push while full sets `overrun_o`, except in a same-cycle pop.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared header/package `uart_pkg`:
  - FSM state encodings: IDLE, START, DATA, STOP.
  - Default `CLKS_PER_BIT`.
  - 8N1 constants: data bits = 8, stop bits = 1.
- Sub-module `uart_rx_fifo`: generic byte FIFO (push, pop, full, empty, show-ahead head). It is instantiated only under `UART_RX_FIFO_EN`.
- Synchronizer, edge detect and FSM stay in `uart_rx`.

## Test plan
- Send 0xA5 at 32 clk/bit → `data_o`=0xA5 and `valid_o`=1 at E+305. `frame_err_o`=0. Pulse `rd_en_i` → `valid_o`=0.
- 8-cycle low glitch on `rx_i` → FSM returns to IDLE at the START check, `valid_o` stays 0, no flags.
- Frame 0x3C with the stop bit driven low → no push, `frame_err_o`=1. Pulse `clr_i` → `frame_err_o`=0.
- Send bytes 0x01..0x05 without reading (depth 4) → `overrun_o`=1. Reads return 0x01, 0x02, 0x03, 0x04, then `valid_o`=0.
- FIFO full, assert `rd_en_i` in the stop-sample cycle of a 5th byte 0x55 → no overrun; the last entry read is 0x55.
- Assert `rst` mid-DATA of a frame → all outputs 0 immediately. The next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, default bit timing and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 32;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic circular byte FIFO with show-ahead head; pointers wrap modulo DEPTH (power of two).
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // NOTE: the storage array has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, falling-edge start detect, bit FSM, buffer with sticky flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       rd_en_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_BITS != 8 || STOP_BITS != 1) begin : g_param_err
    $error("uart_rx: unsupported parameter combination");
  end

  logic sync1, rxs, rxs_prev, fall;

  // Synchronizer and history reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_i;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 push, ferr_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (fall) state_n = ST_START;
      end
      ST_START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n        = '0;
          shreg_n[idx] = rxs;
          idx_n        = idx + 1'b1;
          if (idx == LAST_IDX) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n    = '0;
          state_n  = ST_IDLE;
          push     = rxs;
          ferr_evt = ~rxs;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  logic       buf_full, buf_valid, pop_eff, ovr_evt;
  logic [7:0] buf_data;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rd_en_i),
    .din  (shreg),
    .dout (buf_data),
    .full (buf_full),
    .empty(fifo_empty)
  );

  assign buf_valid = ~fifo_empty;
`else
  logic [7:0] hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      buf_full  <= 1'b0;
    end else if (push && (!buf_full || pop_eff)) begin
      hold_data <= shreg;
      buf_full  <= 1'b1;
    end else if (pop_eff) begin
      buf_full  <= 1'b0;
    end
  end

  assign buf_valid = buf_full;
  assign buf_data  = buf_full ? hold_data : '0;
`endif

  assign pop_eff = rd_en_i & buf_valid;
  assign ovr_evt = push & buf_full & ~pop_eff;

  // A flag-setting event in the same cycle as clr_i wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_evt | (frame_err_o & ~clr_i);
      overrun_o   <= ovr_evt  | (overrun_o   & ~clr_i);
    end
  end

  assign data_o  = buf_data;
  assign valid_o = buf_valid;
  assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: event-scheduled frame model with a per-cycle compare and directed pins.
module tb_uart_rx;

  localparam int CPB      = 32;
  localparam int DEPTH    = 4;
`ifdef UART_RX_FIFO_EN
  localparam int M_DEPTH  = DEPTH;
`else
  localparam int M_DEPTH  = 1;
`endif
  localparam int STOP_OFS = CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, busy_o, frame_err_o, overrun_o;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .rd_en_i    (rd_en_i),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_div = 1000;
  bit cmp_en = 0;
  bit rand_run = 0;

  // Model: frames are known by their start cycle, so busy windows and stop-sample events are scheduled.
  logic [7:0] mq[$];
  bit         busy_map[int];
  logic [7:0] push_ev[int];
  bit         ferr_ev[int];
  bit         m_ferr = 0;
  bit         m_ovr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    busy_map.delete();
    push_ev.delete();
    ferr_ev.delete();
    m_ferr = 0;
    m_ovr  = 0;
  endfunction

  always @(posedge clk) begin
    bit pop, ov, fe;
    if (!rst) begin
      pop = rd_en_i && (mq.size() > 0);
      ov  = 0;
      fe  = ferr_ev.exists(cyc);
      if (pop) void'(mq.pop_front());
      if (push_ev.exists(cyc)) begin
        if (mq.size() < M_DEPTH) mq.push_back(push_ev[cyc]);
        else ov = 1;
      end
      m_ferr = fe | (m_ferr & !clr_i);
      m_ovr  = ov | (m_ovr & !clr_i);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_data",  data_o,      (mq.size() > 0) ? mq[0] : 8'h00);
      check("cyc_valid", valid_o,     mq.size() > 0);
      check("cyc_busy",  busy_o,      busy_map.exists(cyc));
      check("cyc_ferr",  frame_err_o, m_ferr);
      check("cyc_ovr",   overrun_o,   m_ovr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Drives one frame starting now; nbits < 8 abandons it mid-DATA with the line left as is.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_len, input int nbits);
    int e;
    e = cyc + 2;
    for (int c = e + 1; c <= e + STOP_OFS; c++) busy_map[c] = 1;
    if (stop_ok) push_ev[e + STOP_OFS] = b;
    else ferr_ev[e + STOP_OFS] = 1;
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < nbits; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    if (nbits < 8) return;
    rx_i = stop_ok;
    repeat (stop_len) tick();
    rx_i = 1'b1;
    if (!stop_ok) repeat (4) tick();
  endtask

  task automatic glitch(input int len);
    int e;
    e = cyc + 2;
    for (int c = e + 1; c <= e + CPB / 2; c++) busy_map[c] = 1;
    rx_i = 1'b0;
    repeat (len) tick();
    rx_i = 1'b1;
    repeat (CPB / 2 + 4 - len) tick();
  endtask

  task automatic read_expect(input string nm, input logic [7:0] exp);
    check({nm, "_valid"}, valid_o, 1'b1);
    check({nm, "_data"}, data_o, exp);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    rx_i = 1'b1;
    model_clear();
    #1;
    check("rst_mid_data",  data_o,      8'h00);
    check("rst_mid_valid", valid_o,     1'b0);
    check("rst_mid_busy",  busy_o,      1'b0);
    check("rst_mid_ferr",  frame_err_o, 1'b0);
    check("rst_mid_ovr",   overrun_o,   1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int t0, e, kind;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data",  data_o,      8'h00);
    check("reset_valid", valid_o,     1'b0);
    check("reset_busy",  busy_o,      1'b0);
    check("reset_ferr",  frame_err_o, 1'b0);
    check("reset_ovr",   overrun_o,   1'b0);
    rst    = 1'b0;
    cmp_en = 1;
    repeat (5) tick();

    // 0xA5: timing pins around the edge-detect cycle and the push.
    t0 = cyc;
    e  = t0 + 2;
    fork
      send_frame(8'hA5, 1, CPB, 8);
      begin
        wait_until(e);
        check("a5_busy_at_e", busy_o, 1'b0);
        tick();
        check("a5_busy_at_e1", busy_o, 1'b1);
        wait_until(e + STOP_OFS);
        check("a5_valid_at_stop", valid_o, 1'b0);
        check("a5_busy_at_stop", busy_o, 1'b1);
        tick();
        check("a5_valid_e305", valid_o, 1'b1);
        check("a5_data_e305", data_o, 8'hA5);
        check("a5_busy_after", busy_o, 1'b0);
        check("a5_ferr", frame_err_o, 1'b0);
      end
    join
    read_expect("a5_read", 8'hA5);
    check("a5_valid_after_pop", valid_o, 1'b0);

    // 8-cycle glitch: back to IDLE at the start check, nothing recorded.
    t0 = cyc;
    e  = t0 + 2;
    fork
      glitch(8);
      begin
        wait_until(e + CPB / 2);
        check("glitch_busy_at_check", busy_o, 1'b1);
        tick();
        check("glitch_busy_after", busy_o, 1'b0);
      end
    join
    check("glitch_valid", valid_o, 1'b0);
    check("glitch_ferr", frame_err_o, 1'b0);
    check("glitch_ovr", overrun_o, 1'b0);

    // 0x3C with a low stop bit: frame error, no push.
    t0 = cyc;
    e  = t0 + 2;
    fork
      send_frame(8'h3C, 0, CPB, 8);
      begin
        wait_until(e + STOP_OFS);
        check("ferr_before", frame_err_o, 1'b0);
        tick();
        check("ferr_set", frame_err_o, 1'b1);
        check("ferr_no_push", valid_o, 1'b0);
      end
    join
    pulse_clr();
    check("ferr_cleared", frame_err_o, 1'b0);

    // Five bytes without reading: the buffer keeps the first M_DEPTH and flags an overrun.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, CPB, 8);
    check("ovr_set", overrun_o, 1'b1);
    for (int i = 0; i < M_DEPTH; i++) read_expect("ovr_read", 8'(i + 1));
    check("ovr_drained", valid_o, 1'b0);
    pulse_clr();
    check("ovr_cleared", overrun_o, 1'b0);

    // Full buffer, pop in the stop-sample cycle of 0x55: no overrun, 0x55 is the last entry.
    for (int i = 0; i < M_DEPTH; i++) send_frame(8'(8'h11 * (i + 1)), 1, CPB, 8);
    t0 = cyc;
    fork
      send_frame(8'h55, 1, CPB, 8);
      begin
        wait_until(t0 + 2 + STOP_OFS);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
      end
    join
    check("full_pop_no_ovr", overrun_o, 1'b0);
    for (int i = 1; i < M_DEPTH; i++) read_expect("full_pop_read", 8'(8'h11 * (i + 1)));
    read_expect("full_pop_last", 8'h55);
    check("full_pop_drained", valid_o, 1'b0);

    // Reset mid-DATA with a stored byte and a set flag, then a clean 0x5A.
    send_frame(8'h77, 1, CPB, 8);
    send_frame(8'h3C, 0, CPB, 8);
    check("pre_rst_valid", valid_o, 1'b1);
    check("pre_rst_ferr", frame_err_o, 1'b1);
    send_frame(8'hC3, 1, CPB, 3);
    check("pre_rst_busy", busy_o, 1'b1);
    do_reset();
    repeat (4) tick();
    send_frame(8'h5A, 1, CPB, 8);
    read_expect("post_rst", 8'h5A);

    // Randomized traffic: back-to-back frames, bad stops, glitches, random pops and clears.
    rand_run = 1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          rd_div = (k < 15) ? 1000 : 25;
          kind = $urandom_range(0, 9);
          if (kind == 0) glitch($urandom_range(1, 12));
          else if (kind == 1) send_frame(8'($urandom), 0, CPB, 8);
          else send_frame(8'($urandom), 1, $urandom_range(17, 40), 8);
          repeat ($urandom_range(0, 6)) tick();
        end
        rand_run = 0;
      end
      begin
        while (rand_run) begin
          rd_en_i = ($urandom_range(0, rd_div - 1) == 0);
          clr_i   = ($urandom_range(0, 79) == 0);
          tick();
        end
        rd_en_i = 1'b0;
        clr_i   = 1'b0;
      end
    join
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
